uart_tx_arb: RTL and testbench

Round-robin arbiter and frame sequencer that shares one `uart_tx` transmitter among `NUM_REQ` byte producers. It accepts bytes over per-requester valid/ready handshakes and drives a one-cycle `tx_en` pulse plus data to the transmitter. It then holds off further issues for one full frame time, counted on `baud_tick_x16_i`. It sits between the protocol and debug masters and the single UART TX pin.

---
 rtl/uart_tx_arb.sv | 137 +++++++++++++
 tb/tb_uart_tx_arb.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter and frame sequencer sharing one uart_tx among NUM_REQ byte producers.
// Optional burst lock enabled by defining UART_TX_ARB_LOCK_EN; the default build is pure round-robin.
module uart_tx_arb #(
    parameter int NUM_REQ    = 4,
    parameter int GUARD_BITS = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       baud_tick_x16_i,
    input  logic                       parity_en_i,
    input  logic [NUM_REQ-1:0]         req_valid_i,
    input  logic [NUM_REQ*8-1:0]       req_data_i,
    input  logic [NUM_REQ-1:0]         req_lock_i,
    output logic [NUM_REQ-1:0]         req_ready_o,
    output logic                       tx_en_o,
    output logic [7:0]                 tx_data_o,
    output logic                       busy_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_id_o
);

    localparam int IW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    // Handshake: req_ready_o[k] is high only in IDLE, only for the winner, and only
    // while req_valid_i[k] is high, so valid & ready completes in that same cycle.
    logic [1:0]    state_q, state_d;
    logic [7:0]    timer_q, timer_d;
    logic [7:0]    data_q, data_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;
    logic [IW-1:0] winner;
    logic [IW-1:0] rr_idx;
    logic          any_valid;
    logic [7:0]    frame_ticks;

    assign any_valid   = |req_valid_i;
    assign frame_ticks = 8'((10 + GUARD_BITS + (parity_en_i ? 1 : 0)) * 16);

`ifdef UART_TX_ARB_LOCK_EN
    logic lock_q, lock_d;
`else
    logic unused_lock;
    assign unused_lock = ^req_lock_i;
`endif

    // Scan from the farthest candidate down so the nearest valid one after last_q wins.
    always_comb begin
        winner = last_q;
        rr_idx = last_q;
        for (int i = NUM_REQ; i >= 1; i--) begin
            rr_idx = IW'((int'(last_q) + i) % NUM_REQ);
            if (req_valid_i[rr_idx]) begin
                winner = rr_idx;
            end
        end
`ifdef UART_TX_ARB_LOCK_EN
        if (lock_q && req_valid_i[last_q]) begin
            winner = last_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        data_d  = data_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef UART_TX_ARB_LOCK_EN
        lock_d  = lock_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef UART_TX_ARB_LOCK_EN
                if (lock_q && !req_valid_i[last_q]) begin
                    lock_d = 1'b0;
                end
`endif
                if (any_valid) begin
                    data_d  = req_data_i[8*winner +: 8];
                    grant_d = winner;
                    last_d  = winner;
                    state_d = ST_ISSUE;
`ifdef UART_TX_ARB_LOCK_EN
                    lock_d  = req_lock_i[winner];
`endif
                end
            end
            ST_ISSUE: begin
                timer_d = frame_ticks;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (baud_tick_x16_i) begin
                    timer_d = timer_q - 8'd1;
                    if (timer_q == 8'd1) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            data_q  <= '0;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
`ifdef UART_TX_ARB_LOCK_EN
            lock_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q  <= lock_d;
`endif
        end
    end

    assign req_ready_o = (state_q == ST_IDLE && any_valid)
                         ? ({{(NUM_REQ-1){1'b0}}, 1'b1} << winner) : '0;
    assign tx_en_o     = (state_q == ST_ISSUE);
    assign busy_o      = (state_q != ST_IDLE);
    assign tx_data_o   = data_q;
    assign grant_id_o  = grant_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: random ticks/data against a transaction-level arbitration and frame-length model.
module tb_uart_tx_arb;

    localparam int NUM_REQ    = 4;
    localparam int GUARD_BITS = 1;
`ifdef UART_TX_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic                 clk_i = 1'b0;
    logic                 rst_ni = 1'b0;
    logic                 baud_tick = 1'b0;
    logic                 parity_en_i = 1'b0;
    logic [NUM_REQ-1:0]   req_valid_i = '0;
    logic [NUM_REQ*8-1:0] req_data_i = '0;
    logic [NUM_REQ-1:0]   req_lock_i = '0;
    logic [NUM_REQ-1:0]   req_ready_o;
    logic                 tx_en_o;
    logic [7:0]           tx_data_o;
    logic                 busy_o;
    logic [1:0]           grant_id_o;

    uart_tx_arb #(.NUM_REQ(NUM_REQ), .GUARD_BITS(GUARD_BITS)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .baud_tick_x16_i (baud_tick),
        .parity_en_i     (parity_en_i),
        .req_valid_i     (req_valid_i),
        .req_data_i      (req_data_i),
        .req_lock_i      (req_lock_i),
        .req_ready_o     (req_ready_o),
        .tx_en_o         (tx_en_o),
        .tx_data_o       (tx_data_o),
        .busy_o          (busy_o),
        .grant_id_o      (grant_id_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;
    int m_last = NUM_REQ - 1;
    bit m_lock = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference arbitration: held lock wins if still valid, else first valid after the last grant.
    function automatic int pick(input logic [NUM_REQ-1:0] v);
        if (m_lock && v[m_last]) return m_last;
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (v[(m_last + i) % NUM_REQ]) return (m_last + i) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_en"}, 32'(tx_en_o), 0);
        check({tag, "_tx_data"}, 32'(tx_data_o), 0);
        check({tag, "_ready"}, 32'(req_ready_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
        check({tag, "_grant"}, 32'(grant_id_o), 0);
    endtask

    task automatic idle_cycles(input int k);
        logic [31:0] rdy_seen;
        logic [31:0] act_seen;
        rdy_seen = 0;
        act_seen = 0;
        req_valid_i = '0;
        for (int i = 0; i < k; i++) begin
            #1;
            rdy_seen |= 32'(req_ready_o);
            act_seen |= 32'(tx_en_o | busy_o);
            @(negedge clk_i);
        end
        m_lock = 1'b0;
        check("idle_ready", rdy_seen, 0);
        check("idle_activity", act_seen, 0);
    endtask

    // One complete transaction, entered and left on a falling edge with the DUT idle.
    task automatic do_frame(input logic [NUM_REQ-1:0] mask, input logic [NUM_REQ-1:0] lk,
                            input bit par, input bit par_tog, input bit wd, input int rst_at);
        int w;
        int n;
        int cnt;
        int cyc;
        logic [7:0]  byte_exp;
        logic [31:0] rdy_seen;
        logic [31:0] en_seen;
        req_valid_i = mask;
        req_lock_i  = lk;
        parity_en_i = par;
        #1;
        if (m_lock && !mask[m_last]) m_lock = 1'b0;
        w = pick(mask);
        check("ready_onehot", 32'(req_ready_o), 32'(1) << w);
        byte_exp = req_data_i[8*w +: 8];
        @(posedge clk_i);
        m_last = w;
        m_lock = LOCK_EN && lk[w];
        @(negedge clk_i);
        check("issue_tx_en", 32'(tx_en_o), 1);
        check("issue_tx_data", 32'(tx_data_o), 32'(byte_exp));
        check("issue_grant", 32'(grant_id_o), w);
        check("issue_ready", 32'(req_ready_o), 0);
        check("issue_busy", 32'(busy_o), 1);
        req_data_i[8*w +: 8] = 8'($urandom_range(0, 255));
        n = (10 + (par ? 1 : 0) + GUARD_BITS) * 16;
        baud_tick = 1'($urandom_range(0, 1));
        @(posedge clk_i);
        @(negedge clk_i);
        cnt = 0;
        cyc = 0;
        rdy_seen = 0;
        en_seen = 0;
        while (busy_o === 1'b1 && cyc < 3000) begin
            if (rst_at >= 0 && cnt == rst_at) begin
                rst_ni = 1'b0;
                req_valid_i = '0;
                baud_tick = 1'b0;
                #1;
                check_reset_values("midreset");
                m_last = NUM_REQ - 1;
                m_lock = 1'b0;
                @(negedge clk_i);
                rst_ni = 1'b1;
                @(negedge clk_i);
                return;
            end
            rdy_seen |= 32'(req_ready_o);
            en_seen  |= 32'(tx_en_o);
            if (wd) req_valid_i[2] = (cnt < n / 2);
            if (par_tog) parity_en_i = 1'($urandom_range(0, 1));
            baud_tick = 1'($urandom_range(0, 1));
            @(posedge clk_i);
            if (baud_tick) cnt++;
            @(negedge clk_i);
            cyc++;
        end
        baud_tick = 1'b0;
        if (wd) req_valid_i[2] = 1'b0;
        check("frame_ticks", cnt, n);
        check("wait_ready", rdy_seen, 0);
        check("wait_tx_en", en_seen, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_i);
        #1;
        check_reset_values("reset");
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Single byte from requester 1.
        req_data_i[15:8] = 8'hA5;
        do_frame(4'b0010, 4'b0000, 1'b0, 1'b0, 1'b0, -1);
        idle_cycles(3);

        // All requesters continuously valid.
        for (int k = 0; k < NUM_REQ * 8; k++) req_data_i[k] = 1'($urandom_range(0, 1));
        for (int f = 0; f < 5; f++) do_frame(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, -1);

        // Parity on, with parity toggling during WAIT.
        for (int f = 0; f < 2; f++) do_frame(4'b0110, 4'b0000, 1'b1, 1'b1, 1'b0, -1);

        // Requester 2 raises and withdraws valid entirely within WAIT.
        do_frame(4'b0001, 4'b0000, 1'b0, 1'b0, 1'b1, -1);
        idle_cycles(2);
        do_frame(4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0, -1);

        // Reset with 100 ticks left on the timer, then requester 0 must win first.
        req_data_i[31:24] = 8'h5A;
        do_frame(4'b1000, 4'b0000, 1'b0, 1'b0, 1'b0, 76);
        do_frame(4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, -1);
        do_frame(4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, -1);
        do_frame(4'b0011, 4'b0001, 1'b0, 1'b0, 1'b0, -1);
        do_frame(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, -1);
        do_frame(4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0, -1);
        idle_cycles(2);

        // Random masks, locks and parity.
        for (int f = 0; f < 6; f++) begin
            do_frame(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)),
                     1'($urandom_range(0, 1)), 1'b0, 1'b0, -1);
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
